sprite_rom_arbiter: RTL and testbench

- Shares one single-port on-chip sprite ROM among up to N_REQ sprite/overlay requesters: color_mapper pixel fetch, FireBoy/IceGirl frame fetch, ScoreController digit/gem fetch, ElevatorController platform/switch fetch.
- Arbitration: per-cycle round-robin, with an optional strict-priority lane for the real-time pixel path.
- Each request's tag is carried through a fixed-latency read pipeline so every returned byte is steered to the requester that issued it.
- Sits between the sprite controllers and the shared ROM instance in the top level.

---
 rtl/sprite_mem_pkg.sv | 23 ++
 rtl/sprite_rom_arbiter_if.sv | 33 +++
 rtl/sprite_rom_arbiter_rr_pick.sv | 36 +++
 rtl/sprite_rom_arbiter.sv | 118 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_mem_pkg.sv
// Shared types and defaults for the sprite ROM arbiter: requester ids, the
// read-tag record carried through the ROM latency, and a one-hot helper.
package sprite_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int N_REQ_MAX  = 8;

    typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic logic [N_REQ_MAX-1:0] id_onehot(input req_id_t id);
        logic [N_REQ_MAX-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: level requests with flattened
// addresses going in, one-hot grants and steered read data coming back.
interface sprite_rom_arbiter_if
    import sprite_mem_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first active requester after
// i_last, wrapping around, so the most recently served one goes to the back.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_id,
    output logic             o_any
);

    always_comb begin
        logic [IDW:0] w_cand;
        logic         w_found;
        o_gnt   = '0;
        o_id    = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            // Candidate index is (last + k) mod N_REQ, kept one bit wider so the wrap is exact
            w_cand = {1'b0, i_last} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(N_REQ)) begin
                w_cand = w_cand - (IDW+1)'(N_REQ);
            end
            if (!w_found && i_req[w_cand[IDW-1:0]]) begin
                o_gnt[w_cand[IDW-1:0]] = 1'b1;
                o_id                   = w_cand[IDW-1:0];
                w_found                = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among N_REQ requesters with round-robin
// arbitration, an optional priority lane for requester 0, and tag steering of read data.
module sprite_rom_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = 2,
    parameter int HP_EN   = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    sprite_rom_arbiter_if.slave bus,
    output logic                o_mem_rd,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_q,
    output logic                o_busy
);

    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]  w_rr_gnt;
    logic [IDW-1:0]    w_rr_id;
    logic              w_rr_any;
    logic [N_REQ-1:0]  w_gnt;
    logic [IDW-1:0]    w_id;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr_arr [N_REQ];
    logic              w_busy;

    logic [IDW-1:0]    r_last;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    tag_t              r_tag [ROM_LAT];
    logic [N_REQ-1:0]  r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign w_addr_arr[g] = bus.addr[g*ADDR_W +: ADDR_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .i_req  (bus.req),
        .i_last (r_last),
        .o_gnt  (w_rr_gnt),
        .o_id   (w_rr_id),
        .o_any  (w_rr_any)
    );

    // The pixel-path lane beats round-robin; nothing is granted while reset is held
    always_comb begin
        w_gnt = '0;
        w_id  = '0;
        w_any = 1'b0;
        if (!i_reset) begin
            if (HP_EN != 0 && bus.req[0]) begin
                w_gnt[0] = 1'b1;
                w_id     = '0;
                w_any    = 1'b1;
            end else begin
                w_gnt = w_rr_gnt;
                w_id  = w_rr_id;
                w_any = w_rr_any;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last     <= IDW'(N_REQ - 1);
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_mem_rd <= w_any;
            if (w_any) begin
                r_last     <= w_id;
                r_mem_addr <= w_addr_arr[w_id];
            end
            r_tag[0] <= '{valid: w_any, id: req_id_t'(w_id)};
            for (int s = 1; s < ROM_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            // The oldest tag lines up with mem_q, so both are captured on the same edge
            if (r_tag[ROM_LAT-1].valid) begin
                r_rvalid <= N_REQ'(id_onehot(r_tag[ROM_LAT-1].id));
                r_rdata  <= i_mem_q;
            end else begin
                r_rvalid <= '0;
            end
        end
    end

    always_comb begin
        w_busy = r_mem_rd;
        for (int s = 0; s < ROM_LAT; s++) begin
            w_busy = w_busy | r_tag[s].valid;
        end
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_busy     = w_busy;

    a_gnt_onehot : assert property (@(posedge i_clk) $onehot0(w_gnt));

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Drives an HP_EN=1 and an HP_EN=0 arbiter with the same requests and checks both
// against a cycle-level model, a table of expected grants, and corner-case sequences.
module tb_sprite_rom_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    stimReq = 4'b1111;
    logic [N*AW-1:0] stimAddr = '0;

    logic            memRdHp, memRdRr, busyHp, busyRr;
    logic [AW-1:0]   memAddrHp, memAddrRr;
    logic [DW-1:0]   memQHp = '0;
    logic [DW-1:0]   memQRr = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 8;

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) busHp ();
    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) busRr ();

    assign busHp.req  = stimReq;
    assign busHp.addr = stimAddr;
    assign busRr.req  = stimReq;
    assign busRr.addr = stimAddr;

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .HP_EN(1)) dutHp (
        .i_clk(clk), .i_reset(reset), .bus(busHp),
        .o_mem_rd(memRdHp), .o_mem_addr(memAddrHp), .i_mem_q(memQHp), .o_busy(busyHp)
    );

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .HP_EN(0)) dutRr (
        .i_clk(clk), .i_reset(reset), .bus(busRr),
        .o_mem_rd(memRdRr), .o_mem_addr(memAddrRr), .i_mem_q(memQRr), .o_busy(busyRr)
    );

    // ROM stand-in: data is the low address byte, readable the cycle after the strobe
    always @(posedge clk) begin
        if (memRdHp) memQHp <= memAddrHp[7:0];
        if (memRdRr) memQRr <= memAddrRr[7:0];
    end

    typedef struct {
        bit          v;
        int          id;
        logic [AW-1:0] a;
    } issue_t;

    issue_t        gl [2][8];
    int            mLast [2] = '{N-1, N-1};
    int            mPick [2] = '{-1, -1};
    logic [AW-1:0] mAddr [2] = '{'0, '0};
    logic [DW-1:0] mRdata [2] = '{'0, '0};

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int modelPick(input logic [N-1:0] req, input int last, input bit hp);
        if (hp && req[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic modelCheck(input int d);
        logic [N-1:0]  aGnt, aRv, eGnt, eRv;
        logic          aRd, aBusy, eBusy;
        logic [AW-1:0] aAddr;
        logic [DW-1:0] aData;
        issue_t        prev, ret;
        string         who;
        who = (d == 0) ? "hp" : "rr";
        if (d == 0) begin
            aGnt = busHp.gnt; aRv = busHp.rvalid; aData = busHp.rdata;
            aRd = memRdHp; aAddr = memAddrHp; aBusy = busyHp;
        end else begin
            aGnt = busRr.gnt; aRv = busRr.rvalid; aData = busRr.rdata;
            aRd = memRdRr; aAddr = memAddrRr; aBusy = busyRr;
        end
        mPick[d] = reset ? -1 : modelPick(stimReq, mLast[d], d == 0);
        eGnt = (mPick[d] < 0) ? '0 : N'(1 << mPick[d]);
        prev = gl[d][(cyc - 1) % 8];
        ret  = gl[d][(cyc - 1 - LAT) % 8];
        eRv  = ret.v ? N'(1 << ret.id) : '0;
        if (ret.v) mRdata[d] = ret.a[7:0];
        eBusy = 1'b0;
        for (int k = 1; k <= LAT; k++) eBusy = eBusy | gl[d][(cyc - k) % 8].v;
        checkOutput($sformatf("c%0d %s gnt", cyc, who), aGnt, eGnt);
        checkOutput($sformatf("c%0d %s rvalid", cyc, who), aRv, eRv);
        checkOutput($sformatf("c%0d %s rdata", cyc, who), aData, mRdata[d]);
        checkOutput($sformatf("c%0d %s mem_rd", cyc, who), aRd, prev.v);
        checkOutput($sformatf("c%0d %s mem_addr", cyc, who), aAddr, mAddr[d]);
        checkOutput($sformatf("c%0d %s busy", cyc, who), aBusy, eBusy);
    endtask

    task automatic modelAdvance(input int d);
        if (reset) begin
            for (int i = 0; i < 8; i++) gl[d][i].v = 1'b0;
            mLast[d]  = N - 1;
            mAddr[d]  = '0;
            mRdata[d] = '0;
        end else if (mPick[d] >= 0) begin
            gl[d][cyc % 8] = '{v: 1'b1, id: mPick[d], a: stimAddr[mPick[d]*AW +: AW]};
            mLast[d] = mPick[d];
            mAddr[d] = stimAddr[mPick[d]*AW +: AW];
        end else begin
            gl[d][cyc % 8].v = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic [N*AW-1:0] addr);
        @(posedge clk);
        #1;
        reset    = rst;
        stimReq  = req;
        stimAddr = addr;
        @(negedge clk);
        modelCheck(0);
        modelCheck(1);
        modelAdvance(0);
        modelAdvance(1);
        cyc++;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gntHp;
        logic [N-1:0] gntRr;
        logic [N-1:0] rvHp;
        logic [N-1:0] rvRr;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic [N*AW-1:0] tableAddr, addr3, addr5;
        tableAddr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        addr3     = {16'h0040, 16'h1234, 16'h0020, 16'h0010};
        addr5     = {16'h0b0b, 16'h0a0a, 16'h0909, 16'h0808};

        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0001, 4'b1000, 4'b0001, 4'b0001};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 4'b0001, 4'b0100};
        vecs[9]  = '{1'b0, 4'b1001, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
        vecs[10] = '{1'b0, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        vecs[11] = '{1'b0, 4'b1001, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
        vecs[12] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000};
        vecs[13] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
        vecs[14] = '{1'b0, 4'b1010, 4'b1000, 4'b1000, 4'b0001, 4'b1000};
        vecs[15] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        vecs[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        vecs[18] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, tableAddr);
            checkOutput($sformatf("vec%0d gnt hp", i), busHp.gnt, vecs[i].gntHp);
            checkOutput($sformatf("vec%0d gnt rr", i), busRr.gnt, vecs[i].gntRr);
            checkOutput($sformatf("vec%0d rvalid hp", i), busHp.rvalid, vecs[i].rvHp);
            checkOutput($sformatf("vec%0d rvalid rr", i), busRr.rvalid, vecs[i].rvRr);
        end

        // Lone request from requester 2: issue one cycle later, data three cycles later
        applyStimulus(1'b1, 4'b0000, addr3);
        applyStimulus(1'b0, 4'b0100, addr3);
        checkOutput("single gnt", busRr.gnt, 4'b0100);
        applyStimulus(1'b0, 4'b0000, addr3);
        checkOutput("single mem_rd", memRdRr, 1'b1);
        checkOutput("single mem_addr", memAddrRr, 16'h1234);
        checkOutput("single busy t+1", busyRr, 1'b1);
        applyStimulus(1'b0, 4'b0000, addr3);
        checkOutput("single busy t+2", busyRr, 1'b1);
        checkOutput("single early rvalid", busRr.rvalid, 4'b0000);
        applyStimulus(1'b0, 4'b0000, addr3);
        checkOutput("single rvalid", busRr.rvalid, 4'b0100);
        checkOutput("single rdata", busRr.rdata, 8'h34);
        checkOutput("single busy t+3", busyRr, 1'b0);

        // Two reads in flight, then reset: they must vanish and the pointer restart at 3
        applyStimulus(1'b1, 4'b0000, addr5);
        applyStimulus(1'b0, 4'b0110, addr5);
        checkOutput("flush gnt a", busRr.gnt, 4'b0010);
        applyStimulus(1'b0, 4'b0110, addr5);
        checkOutput("flush gnt b", busRr.gnt, 4'b0100);
        applyStimulus(1'b1, 4'b0110, addr5);
        checkOutput("flush gnt in reset", busRr.gnt, 4'b0000);
        applyStimulus(1'b0, 4'b1110, addr5);
        checkOutput("flush restart gnt", busRr.gnt, 4'b0010);
        checkOutput("flush busy", busyRr, 1'b0);
        checkOutput("flush rvalid a", busRr.rvalid, 4'b0000);
        applyStimulus(1'b0, 4'b0000, addr5);
        checkOutput("flush rvalid b", busRr.rvalid, 4'b0000);
        applyStimulus(1'b0, 4'b0000, addr5);
        checkOutput("flush rvalid c", busRr.rvalid, 4'b0000);
        applyStimulus(1'b0, 4'b0000, addr5);
        checkOutput("flush new rvalid", busRr.rvalid, 4'b0010);
        checkOutput("flush new rdata", busRr.rdata, 8'h09);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 63) == 0, N'($urandom_range(0, 15)),
                          {$urandom, $urandom});
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'b0000, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
